jt89_wr_seq: RTL and testbench
==============================

# jt89_wr_seq

Host-side write sequencer for the jt89 PSG bus. It accepts register-level commands (tone period, volume, noise control), queues them in a small FIFO, and serialises each one into the SN76489 latch/data byte sequence on `dout`/`wr_n`. It sits between a CPU or sound-driver FSM and the jt89 write port. Per-channel shadow registers drop redundant tone data bytes.

## Interface
- `AW`, 2: log2 of the FIFO depth; the depth is 2^AW entries.
- `WR_LOW`, 2: number of cycles `wr_n` is held low per byte; must be at least 1.
- `WR_GAP`, 2: minimum number of cycles `wr_n` stays high between bytes; must be at least 1.
- `clk`  in  1  clock; all logic is on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full. A command is accepted on a posedge where `cmd_valid & cmd_ready`.
- `cmd_reg`  in  3  target register, encoded `{ch[1:0], type}`; `type` 0 is tone/ctrl, 1 is volume. `ch` 3 with `type` 0 selects noise ctrl.
- `cmd_data`  in  10  payload: 10-bit tone period, `[3:0]` volume, or `[2:0]` noise ctrl. Unused bits are ignored.
- `cmd_force`  in  1  always send the full byte sequence, bypassing shadow skipping.
- `dout`  out  8  byte presented to the PSG `din`.
- `wr_n`  out  1  write strobe, active low.
- `busy`  out  1  FIFO not empty, or sequencer not in IDLE.

## Operation
- FIFO entries are 14 bits: `{force, reg[2:0], data[9:0]}`.
  - `cmd_ready = !full`. Accepting while full is impossible.
  - Push and pop in the same cycle is legal when the FIFO is neither empty nor full.
  - The sequencer pops only from IDLE, or from GAP on its last cycle.
- Byte encoding:
  - Latch byte is `{1, reg[2:0], data[3:0]}`.
  - Noise latch byte is `{1, 110, 0, data[2:0]}`.
  - Tone data byte is `{00, data[9:4]}`.
- Byte count per command:
  - Volume and noise commands send the latch byte only. Noise is always sent, because every write clears the PSG noise LFSR.
  - Tone commands send the latch byte, then the data byte.
  - A tone command sends the latch byte only when all of these hold: `shadow_valid[ch]`, `data[9:4] == shadow[ch]`, and `!force`.
  - Whenever a data byte is sent, set `shadow[ch] <= data[9:4]` and `shadow_valid[ch] <= 1`.
- FSM states:
  - IDLE: `wr_n = 1`. If the FIFO is non-empty, pop, load `dout` with the latch byte, and go to SETUP.
  - SETUP: 1 cycle with `wr_n` high and `dout` stable. Go to LOW.
  - LOW: `wr_n = 0` for `WR_LOW` cycles. `dout` is held unchanged. Go to GAP.
  - GAP: `wr_n = 1` for `WR_GAP` cycles. On the last GAP cycle:
    - If a data byte is pending, load it into `dout` and go to SETUP.
    - Otherwise, if the FIFO is non-empty, pop, load the next latch byte, and go to SETUP.
    - Otherwise go to IDLE.
- A single down-counter of width `clog2(max(WR_LOW, WR_GAP)) + 1` times both LOW and GAP.

## Timing
- Reset values: `wr_n = 1`, `dout = 8'h00`, `cmd_ready = 1`, `busy = 0`. The FIFO is emptied, all `shadow_valid` bits are cleared, and the FSM enters IDLE.
- Latency, with the sequencer idle and the FIFO empty, for a command accepted at edge E0:
  - Pop happens at E1.
  - `dout` is valid from E2 (SETUP).
  - `wr_n` falls at E3 and rises at E3+`WR_LOW`.
- `dout` is stable from at least 1 cycle before `wr_n` falls until 1 cycle after it rises. A bench sampling `din` on the falling detect always sees the final byte.
- Byte pitch is `1 + WR_LOW + WR_GAP` cycles; the default is 5.
  - A two-byte tone command occupies 10 cycles.
  - Back-to-back commands produce no extra idle cycle.
- `busy` asserts on the edge after acceptance. It deasserts on the edge that enters IDLE with the FIFO empty.
- Reset mid-byte: at the next edge `wr_n = 1`, and any pending data byte and queued commands are discarded. The PSG may therefore have a latched register without its data byte; this is accepted.
- `cmd_data` and `cmd_reg` are sampled only at acceptance.

## Test plan
- Volume only: after reset, send `reg=3'b001`, `data=4'h5` → a single `wr_n` low pulse of 2 cycles with `dout = 8'h95`; falling edge at E3; `busy` low by E0+7.
- Tone full sequence: send `reg=3'b010`, `data=10'h3A7` → bytes `8'hA7` then `8'h3A`, falling edges 5 cycles apart; PSG model reports `tone1 = 10'h3A7`.
- Shadow skip and force:
  - Send tone1 `10'h3A2` after the previous test → only `8'hA2`.
  - Repeat with `cmd_force=1` → `8'hA2` then `8'h3A`.
  - Send tone1 `10'h1A2` → `8'hA2` then `8'h1A`.
- Noise always sent: send `reg=3'b110`, `data=3'h4` twice → two `8'hE4` pulses; the PSG model sees `clr_noise` twice.
- FIFO full: hold `cmd_valid` with 6 volume commands and `AW=2` → `cmd_ready` drops after 4 are queued; all 6 emerge in order with a 5-cycle pitch and no gap beyond `WR_GAP`.
- Reset mid-operation: assert `rst` during LOW of a tone latch byte → next edge `wr_n = 1`, `dout = 0`, `busy = 0`, `cmd_ready = 1`; the next tone command sends both bytes because shadows are invalid.

Source files
------------

// File: rtl/jt89_wr_seq.sv
`default_nettype none
// ============================================================================
// Module : jt89_wr_seq
// Queues PSG register commands and serialises them into SN76489 latch/data
// byte writes, dropping tone data bytes that match the per-channel shadow.
// Rev    : 1.0
// ============================================================================
module jt89_wr_seq #(
    parameter int AW     = 2,
    parameter int WR_LOW = 2,
    parameter int WR_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_reg,
    input  logic [9:0] cmd_data,
    input  logic       cmd_force,
    output logic [7:0] dout,
    output logic       wr_n,
    output logic       busy
);
    localparam int DEPTH = 1 << AW;
    localparam int CMAX  = (WR_LOW > WR_GAP) ? WR_LOW : WR_GAP;
    localparam int CW    = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] LOW_LOAD = CW'(WR_LOW - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(WR_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_LOW   = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    logic [13:0]   mem_q [DEPTH];
    logic [13:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    dout_q, dout_d;
    logic          wr_n_q, wr_n_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_byte_q, pend_byte_d;
    logic [5:0]    shadow_q [4];
    logic [5:0]    shadow_d [4];
    logic [3:0]    shadow_valid_q, shadow_valid_d;

    logic          full, empty, push, pop;
    logic [13:0]   head;
    logic          h_force, h_noise, h_tone, h_skip, h_send_data;
    logic [2:0]    h_reg;
    logic [9:0]    h_data;
    logic [1:0]    h_ch;
    logic [7:0]    h_latch;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = cmd_valid && !full;

    assign head    = mem_q[rd_ptr_q];
    assign h_force = head[13];
    assign h_reg   = head[12:10];
    assign h_data  = head[9:0];
    assign h_ch    = h_reg[2:1];
    assign h_noise = (h_reg == 3'b110);
    assign h_tone  = !h_reg[0] && !h_noise;
    assign h_skip  = shadow_valid_q[h_ch] && (h_data[9:4] == shadow_q[h_ch]) && !h_force;
    assign h_send_data = h_tone && !h_skip;
    assign h_latch = h_noise ? {5'b11100, h_data[2:0]} : {1'b1, h_reg, h_data[3:0]};

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dout_d         = dout_q;
        pend_d         = pend_q;
        pend_byte_d    = pend_byte_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        pop            = 1'b0;
        // Strobe lags the state by one cycle so dout leads the falling edge.
        wr_n_d         = (state_q != S_LOW);

        case (state_q)
            S_IDLE: begin
                if (!empty) pop = 1'b1;
            end
            S_SETUP: begin
                state_d = S_LOW;
                cnt_d   = LOW_LOAD;
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (pend_q) begin
                    dout_d  = pend_byte_q;
                    pend_d  = 1'b0;
                    state_d = S_SETUP;
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shadow commits at pop: the data byte is already guaranteed to follow.
        if (pop) begin
            dout_d      = h_latch;
            pend_d      = h_send_data;
            pend_byte_d = {2'b00, h_data[9:4]};
            state_d     = S_SETUP;
            rd_ptr_d    = rd_ptr_q + 1'b1;
            if (h_send_data) begin
                shadow_d[h_ch]       = h_data[9:4];
                shadow_valid_d[h_ch] = 1'b1;
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = {cmd_force, cmd_reg, cmd_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            dout_q         <= 8'h00;
            wr_n_q         <= 1'b1;
            pend_q         <= 1'b0;
            pend_byte_q    <= 8'h00;
            shadow_valid_q <= 4'b0000;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dout_q         <= dout_d;
            wr_n_q         <= wr_n_d;
            pend_q         <= pend_d;
            pend_byte_q    <= pend_byte_d;
            shadow_valid_q <= shadow_valid_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        shadow_q <= shadow_d;
    end

    assign cmd_ready = !full;
    assign busy      = !empty || (state_q != S_IDLE);
    assign dout      = dout_q;
    assign wr_n      = wr_n_q;

endmodule
`default_nettype wire

// File: tb/tb_jt89_wr_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_jt89_wr_seq
// Directed bench for jt89_wr_seq with a small PSG write-port model.
// Rev    : 1.0
// ============================================================================
module tb_jt89_wr_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_reg;
    logic [9:0] cmd_data;
    logic       cmd_force;
    logic [7:0] dout;
    logic       wr_n;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] bytes_q [$];
    int         fall_q  [$];
    logic       prev_wr_n = 1'b1;
    logic [9:0] tone_m [4];
    logic [2:0] lat_m = 3'b000;
    int         clr_noise = 0;

    jt89_wr_seq #(.AW(2), .WR_LOW(2), .WR_GAP(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_reg   (cmd_reg),
        .cmd_data  (cmd_data),
        .cmd_force (cmd_force),
        .dout      (dout),
        .wr_n      (wr_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PSG write-port model: latches din on each falling strobe.
    always @(negedge clk) begin
        if (prev_wr_n && !wr_n) begin
            bytes_q.push_back(dout);
            fall_q.push_back(cyc);
            if (dout[7]) begin
                lat_m = dout[6:4];
                if (dout[6:4] == 3'b110) clr_noise++;
                else if (!dout[4]) tone_m[dout[6:5]][3:0] = dout[3:0];
            end else if (!lat_m[0] && lat_m != 3'b110) begin
                tone_m[lat_m[2:1]][9:4] = dout[5:0];
            end
        end
        prev_wr_n = wr_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] r, input logic [9:0] d, input logic f);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_reg   = r;
        cmd_data  = d;
        cmd_force = f;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("send_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'b0, busy}, 32'd0);
        tick();
        tick();
    endtask

    task automatic check_bytes(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1);
        check({tag, "_count"}, 32'(bytes_q.size()), 32'(n));
        if (bytes_q.size() > 0) check({tag, "_b0"}, {24'b0, bytes_q[0]}, {24'b0, b0});
        if (n > 1 && bytes_q.size() > 1) begin
            check({tag, "_b1"}, {24'b0, bytes_q[1]}, {24'b0, b1});
            check({tag, "_pitch"}, 32'(fall_q[1] - fall_q[0]), 32'd5);
        end
        bytes_q.delete();
        fall_q.delete();
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 4; i++) tone_m[i] = 10'h000;
        rst = 1'b1; cmd_valid = 1'b0; cmd_reg = 3'b000; cmd_data = 10'h000; cmd_force = 1'b0;
        tick(); tick();
        check("rst_wr_n", {31'b0, wr_n}, 32'd1);
        check("rst_dout", {24'b0, dout}, 32'h00);
        check("rst_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Volume only, with cycle-exact strobe timing from acceptance edge E0
        send(3'b001, 10'h005, 1'b0);
        tick();
        check("vol_busy_e1", {31'b0, busy}, 32'd1);
        tick();
        check("vol_wr_n_e2", {31'b0, wr_n}, 32'd1);
        check("vol_dout_e2", {24'b0, dout}, 32'h95);
        tick();
        check("vol_wr_n_e3", {31'b0, wr_n}, 32'd0);
        tick();
        check("vol_wr_n_e4", {31'b0, wr_n}, 32'd0);
        check("vol_dout_e4", {24'b0, dout}, 32'h95);
        tick();
        check("vol_wr_n_e5", {31'b0, wr_n}, 32'd1);
        tick();
        check("vol_busy_e6", {31'b0, busy}, 32'd0);
        wait_idle();
        check_bytes("vol", 1, 8'h95, 8'h00);

        // Tone full sequence
        send(3'b010, 10'h3A7, 1'b0);
        wait_idle();
        check_bytes("tone", 2, 8'hA7, 8'h3A);
        check("tone1_model", {22'b0, tone_m[1]}, 32'h3A7);

        // Shadow skip, force, and changed upper bits
        send(3'b010, 10'h3A2, 1'b0);
        wait_idle();
        check_bytes("skip", 1, 8'hA2, 8'h00);
        check("skip_model", {22'b0, tone_m[1]}, 32'h3A2);
        send(3'b010, 10'h3A2, 1'b1);
        wait_idle();
        check_bytes("force", 2, 8'hA2, 8'h3A);
        send(3'b010, 10'h1A2, 1'b0);
        wait_idle();
        check_bytes("newhi", 2, 8'hA2, 8'h1A);
        check("newhi_model", {22'b0, tone_m[1]}, 32'h1A2);

        // Noise is never skipped
        n0 = clr_noise;
        send(3'b110, 10'h004, 1'b0);
        send(3'b110, 10'h004, 1'b0);
        wait_idle();
        check_bytes("noise", 2, 8'hE4, 8'hE4);
        check("noise_clr", 32'(clr_noise - n0), 32'd2);

        // FIFO full: one entry is popped at once, four more fill the queue
        for (int i = 0; i < 6; i++) begin
            send(3'b011, 10'(i), 1'b0);
            if (i == 3) check("full_ready_3", {31'b0, cmd_ready}, 32'd1);
            if (i == 4) check("full_ready_4", {31'b0, cmd_ready}, 32'd0);
        end
        wait_idle();
        check("full_count", 32'(bytes_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < bytes_q.size()) check("full_byte", {24'b0, bytes_q[i]}, 32'hB0 + 32'(i));
            if (i > 0 && i < fall_q.size()) check("full_pitch", 32'(fall_q[i] - fall_q[i-1]), 32'd5);
        end
        bytes_q.delete();
        fall_q.delete();

        // Reset during LOW of a tone latch byte, with a second command queued
        send(3'b010, 10'h1A2, 1'b0);
        send(3'b001, 10'h003, 1'b0);
        tick();
        tick();
        check("mid_wr_n_low", {31'b0, wr_n}, 32'd0);
        rst = 1'b1;
        tick();
        check("mid_wr_n", {31'b0, wr_n}, 32'd1);
        check("mid_dout", {24'b0, dout}, 32'h00);
        check("mid_busy", {31'b0, busy}, 32'd0);
        check("mid_ready", {31'b0, cmd_ready}, 32'd1);
        rst = 1'b0;
        bytes_q.delete();
        fall_q.delete();
        for (int i = 0; i < 10; i++) tick();
        check("mid_discard", 32'(bytes_q.size()), 32'd0);
        send(3'b010, 10'h1A2, 1'b0);
        wait_idle();
        check_bytes("post_rst", 2, 8'hA2, 8'h1A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
